// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch (IF) and load/store (D).
// Optional grant/stall counters are compiled in when RISCV_MEM_ARB_STATS_EN is defined.
module riscv_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RISCV_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       if_grant_cnt,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_owner_d;
  logic [3:0]          r_lat_cnt;
  logic [STREAK_W-1:0] r_streak;

  logic w_any_req;
  logic w_starved;
  logic w_grant_if;
  logic w_grant_d;

  assign w_any_req  = if_req | d_req;
  assign w_starved  = (r_streak == STREAK_W'(STARVE_LIMIT));
  // Data wins ties unless fetch has already waited through STARVE_LIMIT data grants.
  assign w_grant_if = if_req & (~d_req | w_starved);
  assign w_grant_d  = d_req & ~w_grant_if;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_lat_cnt <= 4'd0;
      r_streak  <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            mem_en    <= 1'b1;
            mem_we    <= w_grant_d & d_we;
            mem_addr  <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d) begin
              mem_wdata <= d_wdata;
            end
            if (w_grant_d && if_req) begin
              if (!w_starved) begin
                r_streak <= r_streak + STREAK_W'(1);
              end
            end else begin
              r_streak <= '0;
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_en    <= 1'b0;
          r_lat_cnt <= 4'(MEM_LATENCY);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            // mem_we still holds the issued access type, so stores skip the capture.
            if (r_owner_d) begin
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RISCV_MEM_ARB_STATS_EN
  logic w_gnt_if_ev;
  logic w_gnt_d_ev;
  logic w_if_svc;
  logic w_d_svc;
  logic w_stall;

  assign w_gnt_if_ev = (r_state == S_IDLE) & w_grant_if;
  assign w_gnt_d_ev  = (r_state == S_IDLE) & w_grant_d;
  assign w_if_svc    = ((r_state != S_IDLE) & ~r_owner_d) | w_gnt_if_ev;
  assign w_d_svc     = ((r_state != S_IDLE) & r_owner_d) | w_gnt_d_ev;
  assign w_stall     = (if_req & ~w_if_svc) | (d_req & ~w_d_svc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_grant_cnt <= 32'd0;
      d_grant_cnt  <= 32'd0;
      stall_cnt    <= 32'd0;
    end else begin
      if (w_gnt_if_ev && (if_grant_cnt != 32'hFFFF_FFFF)) begin
        if_grant_cnt <= if_grant_cnt + 32'd1;
      end
      if (w_gnt_d_ev && (d_grant_cnt != 32'hFFFF_FFFF)) begin
        d_grant_cnt <= d_grant_cnt + 32'd1;
      end
      if (w_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed steps, a small memory model and an ack scoreboard.
module tb_riscv_mem_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int SL  = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_ack, d_ack, mem_en, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef RISCV_MEM_ARB_STATS_EN
  logic [31:0]   if_grant_cnt, d_grant_cnt, stall_cnt;
  logic [31:0]   snap_if, snap_d, snap_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          is_if;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  riscv_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef RISCV_MEM_ARB_STATS_EN
    ,
    .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Memory model: unwritten words read back as their own byte address.
  logic          tb_clr;
  logic [63:0]   st_valid;
  logic [DW-1:0] st_data [0:63];
  logic [DW-1:0] rd_pipe [0:LAT-1];

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    return st_valid[a[8:3]] ? st_data[a[8:3]] : a;
  endfunction

  always @(posedge clock) begin
    if (tb_clr) begin
      st_valid <= '0;
    end else if (mem_en && mem_we) begin
      st_valid[mem_addr[8:3]] <= 1'b1;
      st_data[mem_addr[8:3]]  <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every ack must match the oldest expected access in owner and data.
  always @(negedge clock) begin
    if (reset_n && (if_ack || d_ack)) begin
      chk("ack_overlap", {62'd0, if_ack, d_ack} == 64'd3, 64'd0);
      chk("ack_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ack_owner_if", 64'(if_ack), 64'(e.is_if));
        $display("[TB] ack %s data %0h (expected %0h)", if_ack ? "IF" : "D",
                 if_ack ? if_rdata : d_rdata, e.data);
        chk("ack_rdata", if_ack ? if_rdata : d_rdata, e.data);
      end
    end
  end

  task automatic access(input bit is_if, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_v);
    bit got;
    sb_q.push_back({is_if, exp_v});
    if (is_if) begin
      if_addr = a; if_req = 1'b1;
    end else begin
      d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clock); #1;
      if (is_if ? if_ack : d_ack) got = 1'b1;
    end
    chk("access_ack_seen", 64'(got), 64'd1);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    int pulses, acks, p0, p1;
    reset_n = 1'b0; tb_clr = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_if_ack", 64'(if_ack), 64'd0);
    chk("rst_d_ack", 64'(d_ack), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    reset_n = 1'b1; tb_clr = 1'b0;
    @(posedge clock); #1;

    // Single load from address 8.
    sb_q.push_back({1'b0, 64'h8});
    d_addr = 64'd8; d_we = 1'b0; d_req = 1'b1;
    @(posedge clock); #1;
    chk("ld_mem_en", 64'(mem_en), 64'd1);
    chk("ld_mem_we", 64'(mem_we), 64'd0);
    chk("ld_mem_addr", mem_addr, 64'd8);
    @(posedge clock); #1;
    chk("ld_mem_en_pulse", 64'(mem_en), 64'd0);
    @(posedge clock); #1;
    chk("ld_no_early_ack", 64'(d_ack), 64'd0);
    @(posedge clock); #1;
    chk("ld_d_ack", 64'(d_ack), 64'd1);
    chk("ld_d_rdata", d_rdata, 64'h8);
    chk("ld_if_ack", 64'(if_ack), 64'd0);
    d_req = 1'b0;
    @(posedge clock); #1;
    chk("ld_ack_one_cycle", 64'(d_ack), 64'd0);

    // Store DEAD to address 16; d_rdata keeps the prior load value.
    sb_q.push_back({1'b0, 64'h8});
    d_addr = 64'd16; d_we = 1'b1; d_wdata = 64'hDEAD; d_req = 1'b1;
    @(posedge clock); #1;
    chk("st_mem_en", 64'(mem_en), 64'd1);
    chk("st_mem_we", 64'(mem_we), 64'd1);
    chk("st_mem_addr", mem_addr, 64'd16);
    chk("st_mem_wdata", mem_wdata, 64'hDEAD);
    acks = 0;
    for (int c = 0; c < 20 && acks == 0; c++) begin
      @(posedge clock); #1;
      if (d_ack) acks = 1;
    end
    chk("st_ack_seen", 64'(acks), 64'd1);
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clock); #1;

    // Load the stored word back.
    access(1'b0, 1'b0, 64'd16, 64'd0, 64'hDEAD);

    // Back-to-back fetches with if_req held across two accesses.
    sb_q.push_back({1'b1, 64'h40});
    sb_q.push_back({1'b1, 64'h40});
    if_addr = 64'h40; if_req = 1'b1;
    pulses = 0; acks = 0; p0 = 0; p1 = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clock); #1;
      if (mem_en) begin
        if (pulses == 0) p0 = c;
        else if (pulses == 1) p1 = c;
        pulses++;
      end
      if (if_ack) begin
        acks++;
        if (acks == 2) if_req = 1'b0;
      end
    end
    chk("bb_mem_en_count", 64'(pulses), 64'd2);
    chk("bb_first_issue", 64'(p0), 64'd1);
    chk("bb_spacing", 64'(p1 - p0), 64'(LAT + 3));
    chk("bb_acks", 64'(acks), 64'd2);

    // Both requesters held: D,D,D,IF repeating.
`ifdef RISCV_MEM_ARB_STATS_EN
    snap_if = if_grant_cnt; snap_d = d_grant_cnt; snap_stall = stall_cnt;
`endif
    for (int g = 0; g < 8; g++) begin
      if ((g % 4) == 3) sb_q.push_back({1'b1, 64'h100});
      else              sb_q.push_back({1'b0, 64'h20});
    end
    d_addr = 64'h20; d_we = 1'b0; if_addr = 64'h100;
    d_req = 1'b1; if_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 100 && acks < 8; c++) begin
      @(posedge clock); #1;
      if (if_ack || d_ack) acks++;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("sim_grants", 64'(acks), 64'd8);
    repeat (3) @(posedge clock);
    #1;
`ifdef RISCV_MEM_ARB_STATS_EN
    chk("stat_if_grants", 64'(if_grant_cnt - snap_if), 64'd2);
    chk("stat_d_grants", 64'(d_grant_cnt - snap_d), 64'd6);
    chk("stat_stall_grew", 64'(stall_cnt > snap_stall), 64'd1);
`endif

    // Reset during WAIT drops the access with no ack.
    d_addr = 64'd24; d_we = 1'b0; d_req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_en", 64'(mem_en), 64'd0);
    chk("arst_mem_addr", mem_addr, 64'd0);
    chk("arst_d_ack", 64'(d_ack), 64'd0);
    chk("arst_d_rdata", d_rdata, 64'd0);
    chk("arst_if_rdata", if_rdata, 64'd0);
    d_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (if_ack || d_ack) acks++;
    end
    chk("arst_no_ack", 64'(acks), 64'd0);
    access(1'b0, 1'b0, 64'd16, 64'd0, 64'hDEAD);
    access(1'b1, 1'b0, 64'h48, 64'd0, 64'h48);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
